// File: rtl/mips_cpu_mem_pkg.sv
// Shared types for the MIPS CPU memory master: access sizes, FSM states, lane widths
// and the request legality check.
package mips_cpu_mem_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_MRG  = 3'd3,
        ST_WR   = 3'd4,
        ST_RSP  = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

    // Illegal size, natural-alignment violation, or word index past the end of RAM.
    function automatic logic access_error(input logic [1:0]  size,
                                          input logic [31:0] addr,
                                          input int unsigned mem_words);
        logic bad_s;
        case (size)
            SZ_BYTE: bad_s = 1'b0;
            SZ_HALF: bad_s = addr[0];
            SZ_WORD: bad_s = (addr[1:0] != 2'b00);
            default: bad_s = 1'b1;
        endcase
        return bad_s || ({2'b00, addr[31:2]} >= mem_words[31:0]);
    endfunction

endpackage

// File: rtl/mips_cpu_mem_lane.sv
// Big-endian lane steering: extract/extend load data and merge sub-word store data
// into the word read back from RAM. Purely combinational.
module mips_cpu_mem_lane
    import mips_cpu_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [BYTE_W-1:0] byte_s;
    logic [HALF_W-1:0] half_s;

    // Select the addressed byte and half; offset 0 is the most significant lane.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (offset)
            2'd0:    byte_s = rdata[31:24];
            2'd1:    byte_s = rdata[23:16];
            2'd2:    byte_s = rdata[15:8];
            2'd3:    byte_s = rdata[7:0];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = rdata[15:0];
        end else begin
            half_s = rdata[31:16];
        end
    end

    // Extend the selected lane to a full word.
    always_comb begin
        load_data = 32'h0000_0000;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SZ_HALF: load_data = {{16{sign_ext & half_s[15]}}, half_s};
            SZ_WORD: load_data = rdata;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Overwrite only the addressed lane(s) of the word fetched from RAM.
    always_comb begin
        merge_data = rdata;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merge_data[31:24] = wdata[7:0];
                    2'd1:    merge_data[23:16] = wdata[7:0];
                    2'd2:    merge_data[15:8]  = wdata[7:0];
                    2'd3:    merge_data[7:0]   = wdata[7:0];
                    default: merge_data = rdata;
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    merge_data[15:0] = wdata[15:0];
                end else begin
                    merge_data[31:16] = wdata[15:0];
                end
            end
            SZ_WORD: merge_data = wdata;
            default: merge_data = rdata;
        endcase
    end

endmodule

// File: rtl/mips_cpu_mem_master.sv
// Load/store initiator for a single-port word RAM with 1-cycle registered read.
// Optional MEM_MASTER_STATS_EN adds saturating load/store/error response counters.
module mips_cpu_mem_master
    import mips_cpu_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
`ifdef MEM_MASTER_STATS_EN
    ,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errors
`endif
);

    state_e      state_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic [31:0] rsp_rdata_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic [31:0] mem_address_r;
    logic [31:0] wr_data_r;

    logic        store_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [1:0]  offset_r;
    logic [31:0] wdata_r;

    logic        accept_s;
    logic [31:0] load_s;
    logic [31:0] merge_s;

    assign accept_s = req_valid & req_ready_r;

    mips_cpu_mem_lane u_lane (
        .size       (size_r),
        .offset     (offset_r),
        .sign_ext   (signed_r),
        .wdata      (wdata_r),
        .rdata      (mem_readdata),
        .load_data  (load_s),
        .merge_data (merge_s)
    );

    // Request sequencer: one outstanding access, all bus/response outputs registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_err_r     <= 1'b0;
            rsp_rdata_r   <= 32'h0000_0000;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_address_r <= 32'h0000_0000;
            wr_data_r     <= 32'h0000_0000;
            store_r       <= 1'b0;
            size_r        <= 2'b00;
            signed_r      <= 1'b0;
            offset_r      <= 2'b00;
            wdata_r       <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        store_r     <= req_store;
                        size_r      <= req_size;
                        signed_r    <= req_signed;
                        offset_r    <= req_addr[1:0];
                        wdata_r     <= req_wdata;
                        req_ready_r <= 1'b0;
                        rsp_rdata_r <= 32'h0000_0000;
                        if (access_error(req_size, req_addr, MEM_WORDS)) begin
                            state_r     <= ST_ERR;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                        end else if (req_store && (req_size == SZ_WORD)) begin
                            state_r       <= ST_WR;
                            mem_write_r   <= 1'b1;
                            wr_data_r     <= req_wdata;
                            mem_address_r <= {2'b00, req_addr[31:2]};
                        end else begin
                            // Loads and sub-word stores both start by fetching the word.
                            state_r       <= ST_RD;
                            mem_read_r    <= 1'b1;
                            mem_address_r <= {2'b00, req_addr[31:2]};
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    mem_read_r <= 1'b0;
                    if (store_r) begin
                        state_r     <= ST_MRG;
                        mem_write_r <= 1'b1;
                    end else begin
                        state_r <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    rsp_rdata_r <= load_s;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RSP;
                end
                ST_MRG, ST_WR: begin
                    mem_write_r <= 1'b0;
                    wr_data_r   <= 32'h0000_0000;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RSP;
                end
                ST_RSP, ST_ERR: begin
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    wr_data_r   <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Merged word only exists while the RAM read data is on the bus, so MRG data is combinational.
    always_comb begin
        if (state_r == ST_MRG) begin
            mem_writedata = merge_s;
        end else begin
            mem_writedata = wr_data_r;
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign mem_address = mem_address_r;
    // Reset mid-operation must not let a strobe reach the RAM in the reset cycle itself.
    assign mem_read    = mem_read_r & ~reset;
    assign mem_write   = mem_write_r & ~reset;

`ifdef MEM_MASTER_STATS_EN
    logic [15:0] loads_r;
    logic [15:0] stores_r;
    logic [15:0] errors_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'h0001;
        end
    endfunction

    // Count each response once, by outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            loads_r  <= 16'h0000;
            stores_r <= 16'h0000;
            errors_r <= 16'h0000;
        end else if (rsp_valid_r) begin
            if (rsp_err_r) begin
                errors_r <= sat_inc(errors_r);
            end else if (store_r) begin
                stores_r <= sat_inc(stores_r);
            end else begin
                loads_r <= sat_inc(loads_r);
            end
        end else begin
            loads_r  <= loads_r;
            stores_r <= stores_r;
            errors_r <= errors_r;
        end
    end

    assign stat_loads  = loads_r;
    assign stat_stores = stores_r;
    assign stat_errors = errors_r;
`endif

endmodule
